// File: rtl/move_pulse_gen_if.sv
// Board-side switch inputs and conditioned move outputs of move_pulse_gen.
// master = switch/board side, slave = the pulse generator.
interface move_pulse_gen_if;
  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       i_Switch_3;
  logic       i_Switch_4;
  logic       i_Game_Active;
  logic       o_Up_Mvt;
  logic       o_Down_Mvt;
  logic       o_Left_Mvt;
  logic       o_Right_Mvt;
  logic [1:0] o_Held_Dir;
  logic       o_Holding;

  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4, i_Game_Active,
    input  o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Held_Dir, o_Holding
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4, i_Game_Active,
    output o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Held_Dir, o_Holding
  );
endinterface

// File: rtl/move_pulse_gen.sv
// Frogger movement switch conditioning: synchronise, debounce, arbitrate and
// turn switch holds into single-cycle move pulses with auto-repeat.
//
// state  | meaning
// IDLE   | waiting for a fresh press event while the game is active
// DELAY  | pulse issued, counting hold time until the first repeat
// REPEAT | auto-repeating every c_REPEAT_PERIOD cycles while held
module move_pulse_gen #(
  parameter int c_DEBOUNCE_LIMIT = 250000,
  parameter int c_REPEAT_DELAY   = 12500000,
  parameter int c_REPEAT_PERIOD  = 5000000
) (
  input logic             i_Clk,
  input logic             i_Rst_L,
  move_pulse_gen_if.slave mpg
);

  localparam int c_DB_W  = $clog2(c_DEBOUNCE_LIMIT > 1 ? c_DEBOUNCE_LIMIT : 2);
  localparam int c_RP_MX = (c_REPEAT_DELAY > c_REPEAT_PERIOD) ? c_REPEAT_DELAY : c_REPEAT_PERIOD;
  localparam int c_RP_W  = $clog2(c_RP_MX > 1 ? c_RP_MX : 2);

  localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(c_DEBOUNCE_LIMIT - 1);
  localparam logic [c_RP_W-1:0] c_DLY_LAST = c_RP_W'(c_REPEAT_DELAY - 1);
  localparam logic [c_RP_W-1:0] c_PER_LAST = c_RP_W'(c_REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [3:0]        w_raw;
  logic [3:0]        r_sync1;
  logic [3:0]        r_sync2;
  logic [3:0]        r_deb;
  logic [3:0]        r_deb_prev;
  logic [3:0]        r_armed;
  logic [1:0]        r_sync_vld;
  logic [c_DB_W-1:0] r_db_cnt [4];
  logic [3:0]        w_press;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_RP_W-1:0] r_rep_cnt;
  logic [c_RP_W-1:0] w_rep_cnt_nxt;
  logic [1:0]        r_dir;
  logic [1:0]        w_dir_nxt;
  logic [1:0]        w_dir_sel;
  logic [3:0]        r_pulse;
  logic [3:0]        w_pulse_nxt;
  logic              w_held;

  assign w_raw = {mpg.i_Switch_4, mpg.i_Switch_3, mpg.i_Switch_2, mpg.i_Switch_1};

  // A switch held through reset must be seen released before it may fire.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb      <= '0;
      r_deb_prev <= '0;
      r_armed    <= '0;
      r_sync_vld <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == c_DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + c_DB_W'(1);
        end
        if (r_sync_vld[1] && !r_sync2[i] && !r_deb[i]) r_armed[i] <= 1'b1;
      end
    end
  end

  assign w_press = r_deb & ~r_deb_prev & r_armed;
  assign w_held  = r_deb[r_dir];

  always_comb begin
    w_dir_sel = 2'd3;
    if (w_press[0])      w_dir_sel = 2'd0;
    else if (w_press[1]) w_dir_sel = 2'd1;
    else if (w_press[2]) w_dir_sel = 2'd2;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rep_cnt_nxt = r_rep_cnt;
    w_dir_nxt     = r_dir;
    w_pulse_nxt   = 4'b0000;
    if (!mpg.i_Game_Active) begin
      w_state_nxt   = IDLE;
      w_rep_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_press) begin
            w_dir_nxt              = w_dir_sel;
            w_pulse_nxt[w_dir_sel] = 1'b1;
            w_rep_cnt_nxt          = '0;
            w_state_nxt            = DELAY;
          end
        end
        DELAY: begin
          if (!w_held) begin
            w_state_nxt   = IDLE;
            w_rep_cnt_nxt = '0;
          end else if (r_rep_cnt == c_DLY_LAST) begin
            w_pulse_nxt[r_dir] = 1'b1;
            w_rep_cnt_nxt      = '0;
            w_state_nxt        = REPEAT;
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + c_RP_W'(1);
          end
        end
        REPEAT: begin
          if (!w_held) begin
            w_state_nxt   = IDLE;
            w_rep_cnt_nxt = '0;
          end else if (r_rep_cnt == c_PER_LAST) begin
            w_pulse_nxt[r_dir] = 1'b1;
            w_rep_cnt_nxt      = '0;
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + c_RP_W'(1);
          end
        end
        default: begin
          w_state_nxt   = IDLE;
          w_rep_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= IDLE;
      r_rep_cnt <= '0;
      r_dir     <= 2'd0;
      r_pulse   <= 4'b0000;
    end else begin
      r_state   <= w_state_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_pulse   <= w_pulse_nxt;
    end
  end

  assign mpg.o_Up_Mvt    = r_pulse[0];
  assign mpg.o_Down_Mvt  = r_pulse[1];
  assign mpg.o_Left_Mvt  = r_pulse[2];
  assign mpg.o_Right_Mvt = r_pulse[3];
  assign mpg.o_Held_Dir  = r_dir;
  assign mpg.o_Holding   = (r_state != IDLE);

endmodule

// File: tb/tb_move_pulse_gen.sv
// Directed bench for move_pulse_gen with short debounce/repeat parameters.
// Cycle c of a run is the value seen just after the (c-1)th edge following t0.
module tb_move_pulse_gen;
  localparam int c_DB  = 4;
  localparam int c_DLY = 20;
  localparam int c_PER = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  move_pulse_gen_if mpg();

  move_pulse_gen #(
    .c_DEBOUNCE_LIMIT(c_DB),
    .c_REPEAT_DELAY  (c_DLY),
    .c_REPEAT_PERIOD (c_PER)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .mpg    (mpg)
  );

  typedef struct {
    logic [3:0] sw;
    int         hold;
    logic       act;
    int         dir;
    int         n;
    int         cyc [6];
  } vec_t;

  vec_t vecs [8];
  int   checks = 0;
  int   errors = 0;
  int   g_cnt   [4];
  int   g_first [4];
  int   g_multi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_sw(input logic [3:0] s);
    mpg.i_Switch_1 = s[0];
    mpg.i_Switch_2 = s[1];
    mpg.i_Switch_3 = s[2];
    mpg.i_Switch_4 = s[3];
  endtask

  function automatic logic [3:0] pulses();
    return {mpg.o_Right_Mvt, mpg.o_Left_Mvt, mpg.o_Down_Mvt, mpg.o_Up_Mvt};
  endfunction

  function automatic int total();
    return g_cnt[0] + g_cnt[1] + g_cnt[2] + g_cnt[3];
  endfunction

  task automatic observe(input int n);
    logic [3:0] p;
    g_multi = 0;
    for (int d = 0; d < 4; d++) begin
      g_cnt[d]   = 0;
      g_first[d] = -1;
    end
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      p = pulses();
      if ($countones(p) > 1) g_multi++;
      for (int d = 0; d < 4; d++) begin
        if (p[d]) begin
          g_cnt[d]++;
          if (g_first[d] < 0) g_first[d] = j + 1;
        end
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         pc [$];
    int         pd [$];
    int         multi;
    int         c;
    logic [3:0] p;
    logic       exp_hold;
    string      tag;
    multi = 0;
    tag   = $sformatf("vec%0d", idx);
    mpg.i_Game_Active = v.act;
    set_sw(v.sw);
    for (int j = 0; j < v.hold + 14; j++) begin
      @(posedge clk); #1;
      c = j + 1;
      p = pulses();
      if ($countones(p) > 1) multi++;
      for (int d = 0; d < 4; d++) begin
        if (p[d]) begin
          pc.push_back(c);
          pd.push_back(d);
        end
      end
      if (c == 6 || c == 7 || c == v.hold + 6 || c == v.hold + 7) begin
        exp_hold = (v.n > 0) && (c >= 7) && (c <= v.hold + 6);
        chk($sformatf("%s holding@%0d", tag, c), 32'(mpg.o_Holding), 32'(exp_hold));
      end
      if (c == 7 && v.n > 0) chk($sformatf("%s held_dir", tag), 32'(mpg.o_Held_Dir), v.dir);
      if (j == v.hold - 1) set_sw(4'b0000);
    end
    chk($sformatf("%s pulse_count", tag), pc.size(), v.n);
    for (int i = 0; i < pc.size() && i < v.n; i++) begin
      chk($sformatf("%s pulse%0d_cycle", tag, i), pc[i], v.cyc[i]);
      chk($sformatf("%s pulse%0d_dir", tag, i), pd[i], v.dir);
    end
    chk($sformatf("%s one_hot", tag), multi, 0);
    mpg.i_Game_Active = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    logic r;
    int   tot;

    vecs[0] = '{4'b0001, 10, 1'b1, 0, 1, '{7, 0, 0, 0, 0, 0}};
    vecs[1] = '{4'b0100, 60, 1'b1, 2, 6, '{7, 27, 35, 43, 51, 59}};
    vecs[2] = '{4'b0010, 28, 1'b1, 1, 2, '{7, 27, 0, 0, 0, 0}};
    vecs[3] = '{4'b1000, 29, 1'b1, 3, 3, '{7, 27, 35, 0, 0, 0}};
    vecs[4] = '{4'b0001,  3, 1'b1, 0, 0, '{0, 0, 0, 0, 0, 0}};
    vecs[5] = '{4'b0001,  4, 1'b1, 0, 1, '{7, 0, 0, 0, 0, 0}};
    vecs[6] = '{4'b1001, 10, 1'b1, 0, 1, '{7, 0, 0, 0, 0, 0}};
    vecs[7] = '{4'b0010, 10, 1'b0, 1, 0, '{0, 0, 0, 0, 0, 0}};

    set_sw(4'b0000);
    mpg.i_Game_Active = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pulses",   32'(pulses()), 0);
    chk("reset holding",  32'(mpg.o_Holding), 0);
    chk("reset held_dir", 32'(mpg.o_Held_Dir), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Bouncy Right: high/low every two cycles never settles long enough.
    tot = 0;
    r   = 1'b1;
    set_sw({r, 3'b000});
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      tot += $countones(pulses());
      if (j % 2 == 1) begin
        r = ~r;
        set_sw({r, 3'b000});
      end
    end
    set_sw(4'b0000);
    observe(12);
    chk("bounce pulses", tot + total(), 0);

    // Simultaneous Up+Right; Right left held after Up releases must not fire.
    set_sw(4'b1001);
    observe(20);
    chk("simul up_count",    g_cnt[0], 1);
    chk("simul up_first",    g_first[0], 7);
    chk("simul right_count", g_cnt[3], 0);
    set_sw(4'b1000);
    observe(30);
    chk("right_held pulses", total(), 0);
    chk("right_held holding", 32'(mpg.o_Holding), 0);
    set_sw(4'b0000);
    observe(15);
    set_sw(4'b1000);
    observe(20);
    chk("repress right_count", g_cnt[3], 1);
    chk("repress right_first", g_first[3], 7);
    set_sw(4'b0000);
    observe(15);

    // Game inactive during press, then activated with Down still held.
    mpg.i_Game_Active = 1'b0;
    set_sw(4'b0010);
    observe(20);
    chk("inactive pulses", total(), 0);
    mpg.i_Game_Active = 1'b1;
    observe(20);
    chk("activated_held pulses", total(), 0);
    set_sw(4'b0000);
    observe(15);
    set_sw(4'b0010);
    observe(20);
    chk("active down_count", g_cnt[1], 1);
    chk("active down_first", g_first[1], 7);
    set_sw(4'b0000);
    observe(15);

    // Asynchronous reset in the middle of REPEAT with the switch still held.
    set_sw(4'b0100);
    observe(30);
    chk("pre_reset left_count", g_cnt[2], 2);
    chk("pre_reset holding", 32'(mpg.o_Holding), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset pulses",  32'(pulses()), 0);
    chk("async_reset holding", 32'(mpg.o_Holding), 0);
    chk("async_reset dir",     32'(mpg.o_Held_Dir), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    observe(30);
    chk("held_through_reset pulses", total(), 0);
    set_sw(4'b0000);
    observe(15);
    set_sw(4'b0100);
    observe(20);
    chk("post_reset left_count", g_cnt[2], 1);
    chk("post_reset left_first", g_first[2], 7);
    chk("post_reset one_hot", g_multi, 0);
    set_sw(4'b0000);
    observe(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
